// File: rtl/fetch_unit_if.sv
// Instruction ROM port between the fetch stage (master) and the synchronous ROM (slave).
// Read data returns one cycle after a cycle with irom_en high.
interface fetch_unit_if;
   logic        irom_en;
   logic [31:0] irom_addr;
   logic [31:0] irom_rdata;

   modport master (output irom_en, output irom_addr, input irom_rdata);
   modport slave  (input irom_en, input irom_addr, output irom_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, ROM drive, IF/ID register with one-entry skid buffer and flush bubble.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_selected,
   input  logic        pre_taken,
   input  logic        stop_IF_ID,
   input  logic        risk_Control,
   output logic [31:0] pc_current,
   fetch_unit_if.master irom,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   output logic [31:0] id_inst,
   output logic        id_pre_taken
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   logic        flush;
   logic        adv;
   logic        skid_valid;
   logic [31:0] skid_q;

   // A flush must always move the PC, so it overrides a stall.
   assign flush = risk_Control;
   assign adv   = flush | ~stop_IF_ID;

   assign irom.irom_en   = adv & ~rst;
   assign irom.irom_addr = pc_current;

   assign id_inst = ~id_valid ? NOP_INST : (skid_valid ? skid_q : irom.irom_rdata);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_current <= RESET_PC;
      end else if (adv) begin
         pc_current <= pc_selected;
      end
   end

   // On flush only the valid bit is cleared; the payload fields are left as they were.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid     <= 1'b0;
         id_pc        <= 32'h0;
         id_pc4       <= 32'h0;
         id_pre_taken <= 1'b0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (!stop_IF_ID) begin
         id_valid     <= 1'b1;
         id_pc        <= pc_current;
         id_pc4       <= pc_current + 32'd4;
         id_pre_taken <= pre_taken;
      end
   end

   // The ROM word is only valid in the first stall cycle, so it is captured once and kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid <= 1'b0;
         skid_q     <= 32'h0;
      end else if (adv) begin
         skid_valid <= 1'b0;
      end else if (id_valid && !skid_valid) begin
         skid_valid <= 1'b1;
         skid_q     <= irom.irom_rdata;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= 32'h0;
         perf_flush_cnt <= 32'h0;
      end else begin
         if (!flush && !stop_IF_ID) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (flush) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
